ddr_port_arbiter: RTL and testbench

Shares one DDR memory port between the L1 instruction cache and the L1 data cache miss/writeback interfaces. It sits between the two l1cache instances and the external DDR controller, replacing the two separate DDR ports with one. It serialises whole-cacheline transactions, arbitrates round-robin on ties, and registers all DDR-side and cache-side outputs.

---
 rtl/ddr_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_ddr_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: shares one DDR line port between the L1 icache and the
// L1 dcache. It serialises whole-cacheline transactions, breaks ties
// round-robin and drives every DDR-side and cache-side output from a register.
module ddr_port_arbiter #(
   parameter int ADDR_BITS = 32,
   parameter int LINE_BITS = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   // icache miss port
   input  logic [ADDR_BITS-1:0] icache_iddr_addr,
   input  logic                 icache_iddr_read,
   output logic [LINE_BITS-1:0] iddr_icache_rdata,
   output logic                 iddr_icache_resp,
   // dcache miss / writeback port
   input  logic [ADDR_BITS-1:0] dcache_dddr_addr,
   input  logic                 dcache_dddr_read,
   input  logic                 dcache_dddr_write,
   input  logic [LINE_BITS-1:0] dcache_dddr_wdata,
   output logic [LINE_BITS-1:0] dddr_dcache_rdata,
   output logic                 dddr_dcache_resp,
   // shared DDR controller port
   output logic [ADDR_BITS-1:0] arb_ddr_addr,
   output logic                 arb_ddr_read,
   output logic                 arb_ddr_write,
   output logic [LINE_BITS-1:0] arb_ddr_wdata,
   input  logic [LINE_BITS-1:0] ddr_arb_rdata,
   input  logic                 ddr_arb_resp
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ISSUE_I = 3'd1;
   localparam logic [2:0] ST_ISSUE_D = 3'd2;
   localparam logic [2:0] ST_RESP_I  = 3'd3;
   localparam logic [2:0] ST_RESP_D  = 3'd4;

   localparam logic GRANT_I = 1'b0;
   localparam logic GRANT_D = 1'b1;

   logic [2:0]           state_q,  state_d;
   logic                 last_q,   last_d;
   logic [ADDR_BITS-1:0] addr_q,   addr_d;
   logic                 rd_q,     rd_d;
   logic                 wr_q,     wr_d;
   logic [LINE_BITS-1:0] wdata_q,  wdata_d;
   logic [LINE_BITS-1:0] irdata_q, irdata_d;
   logic [LINE_BITS-1:0] drdata_q, drdata_d;
   logic                 iresp_q,  iresp_d;
   logic                 dresp_q,  dresp_d;

   logic i_req;
   logic d_req;

   assign i_req = icache_iddr_read;
   assign d_req = dcache_dddr_read | dcache_dddr_write;

   // Next-state logic: arbitration in IDLE, DDR completion in ISSUE, one-cycle resp in RESP
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      addr_d   = addr_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      wdata_d  = wdata_q;
      irdata_d = irdata_q;
      drdata_d = drdata_q;
      iresp_d  = 1'b0;
      dresp_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // icache wins when alone, or on a tie when dcache was served last
            if (i_req && (!d_req || last_q == GRANT_D)) begin
               state_d = ST_ISSUE_I;
               last_d  = GRANT_I;
               addr_d  = icache_iddr_addr;
               rd_d    = 1'b1;
               wr_d    = 1'b0;
            end else if (d_req) begin
               // read+write together is a dcache protocol error; the write wins
               state_d = ST_ISSUE_D;
               last_d  = GRANT_D;
               addr_d  = dcache_dddr_addr;
               rd_d    = ~dcache_dddr_write;
               wr_d    = dcache_dddr_write;
               wdata_d = dcache_dddr_wdata;
            end
         end

         ST_ISSUE_I: begin
            if (ddr_arb_resp) begin
               irdata_d = ddr_arb_rdata;
               rd_d     = 1'b0;
               wr_d     = 1'b0;
               iresp_d  = 1'b1;
               state_d  = ST_RESP_I;
            end
         end

         ST_ISSUE_D: begin
            if (ddr_arb_resp) begin
               // a writeback leaves the previously returned line untouched
               if (rd_q) begin
                  drdata_d = ddr_arb_rdata;
               end
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               dresp_d = 1'b1;
               state_d = ST_RESP_D;
            end
         end

         ST_RESP_I,
         ST_RESP_D: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any transaction in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         last_q   <= GRANT_I;
         addr_q   <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         wdata_q  <= '0;
         irdata_q <= '0;
         drdata_q <= '0;
         iresp_q  <= 1'b0;
         dresp_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         addr_q   <= addr_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         wdata_q  <= wdata_d;
         irdata_q <= irdata_d;
         drdata_q <= drdata_d;
         iresp_q  <= iresp_d;
         dresp_q  <= dresp_d;
      end
   end

   assign arb_ddr_addr      = addr_q;
   assign arb_ddr_read      = rd_q;
   assign arb_ddr_write     = wr_q;
   assign arb_ddr_wdata     = wdata_q;
   assign iddr_icache_rdata = irdata_q;
   assign iddr_icache_resp  = iresp_q;
   assign dddr_dcache_rdata = drdata_q;
   assign dddr_dcache_resp  = dresp_q;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed bench for ddr_port_arbiter: single-requester latency, tie-breaking,
// continuous round-robin, read+write collision, dropped request, mid-flight reset.
module tb_ddr_port_arbiter;

   localparam int AB = 32;
   localparam int LB = 256;

   localparam logic [LB-1:0] LINE_A5 = {32{8'hA5}};
   localparam logic [LB-1:0] LINE_C3 = {32{8'hC3}};
   localparam logic [LB-1:0] LINE_77 = {32{8'h77}};
   localparam logic [LB-1:0] LINE_5A = {32{8'h5A}};
   localparam logic [LB-1:0] LINE_EE = {32{8'hEE}};
   localparam logic [LB-1:0] WD_1234 = {8{32'h1234_5678}};
   localparam logic [LB-1:0] WD_DEAD = {8{32'hDEAD_BEEF}};
   localparam logic [LB-1:0] WD_0707 = {8{32'h0707_0707}};

   logic          clk = 1'b0;
   logic          rst;
   logic [AB-1:0] icache_iddr_addr;
   logic          icache_iddr_read;
   logic [LB-1:0] iddr_icache_rdata;
   logic          iddr_icache_resp;
   logic [AB-1:0] dcache_dddr_addr;
   logic          dcache_dddr_read;
   logic          dcache_dddr_write;
   logic [LB-1:0] dcache_dddr_wdata;
   logic [LB-1:0] dddr_dcache_rdata;
   logic          dddr_dcache_resp;
   logic [AB-1:0] arb_ddr_addr;
   logic          arb_ddr_read;
   logic          arb_ddr_write;
   logic [LB-1:0] arb_ddr_wdata;
   logic [LB-1:0] ddr_arb_rdata;
   logic          ddr_arb_resp;

   int n_vec  = 0;
   int n_miss = 0;

   ddr_port_arbiter #(.ADDR_BITS(AB), .LINE_BITS(LB)) dut (
      .clk               (clk),
      .rst               (rst),
      .icache_iddr_addr  (icache_iddr_addr),
      .icache_iddr_read  (icache_iddr_read),
      .iddr_icache_rdata (iddr_icache_rdata),
      .iddr_icache_resp  (iddr_icache_resp),
      .dcache_dddr_addr  (dcache_dddr_addr),
      .dcache_dddr_read  (dcache_dddr_read),
      .dcache_dddr_write (dcache_dddr_write),
      .dcache_dddr_wdata (dcache_dddr_wdata),
      .dddr_dcache_rdata (dddr_dcache_rdata),
      .dddr_dcache_resp  (dddr_dcache_resp),
      .arb_ddr_addr      (arb_ddr_addr),
      .arb_ddr_read      (arb_ddr_read),
      .arb_ddr_write     (arb_ddr_write),
      .arb_ddr_wdata     (arb_ddr_wdata),
      .ddr_arb_rdata     (ddr_arb_rdata),
      .ddr_arb_resp      (ddr_arb_resp)
   );

   always #5 clk = ~clk;

   task automatic chk_vec(input string tag, input logic [LB-1:0] act, input logic [LB-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // advance one clock and settle just past the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // DDR completes in the current cycle; returns positioned in the RESP cycle
   task automatic ddr_reply(input logic [LB-1:0] line);
      ddr_arb_resp  = 1'b1;
      ddr_arb_rdata = line;
      tick();
      ddr_arb_resp  = 1'b0;
      ddr_arb_rdata = '0;
   endtask

   task automatic chk_idle_port(input string tag);
      chk_vec({tag, "_rd"}, arb_ddr_read, 1'b0);
      chk_vec({tag, "_wr"}, arb_ddr_write, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [LB-1:0] exp_d;
      logic [LB-1:0] line_k;
      logic [7:0]    b;

      rst               = 1'b1;
      icache_iddr_addr  = '0;
      icache_iddr_read  = 1'b0;
      dcache_dddr_addr  = '0;
      dcache_dddr_read  = 1'b0;
      dcache_dddr_write = 1'b0;
      dcache_dddr_wdata = '0;
      ddr_arb_rdata     = '0;
      ddr_arb_resp      = 1'b0;
      tick();
      tick();
      chk_vec("rst_addr",   arb_ddr_addr, '0);
      chk_vec("rst_rd",     arb_ddr_read, 1'b0);
      chk_vec("rst_wr",     arb_ddr_write, 1'b0);
      chk_vec("rst_wdata",  arb_ddr_wdata, '0);
      chk_vec("rst_irdata", iddr_icache_rdata, '0);
      chk_vec("rst_drdata", dddr_dcache_rdata, '0);
      chk_vec("rst_iresp",  iddr_icache_resp, 1'b0);
      chk_vec("rst_dresp",  dddr_dcache_resp, 1'b0);
      rst = 1'b0;

      // icache read alone, DDR answers 3 cycles after the command
      icache_iddr_addr = 32'h0000_1000;
      icache_iddr_read = 1'b1;
      tick();
      chk_vec("t1_cmd_rd",   arb_ddr_read, 1'b1);
      chk_vec("t1_cmd_wr",   arb_ddr_write, 1'b0);
      chk_vec("t1_cmd_addr", arb_ddr_addr, 32'h0000_1000);
      tick();
      tick();
      chk_vec("t1_held_rd",  arb_ddr_read, 1'b1);
      chk_vec("t1_no_early", iddr_icache_resp, 1'b0);
      tick();
      ddr_reply(LINE_A5);
      chk_vec("t1_iresp",    iddr_icache_resp, 1'b1);
      chk_vec("t1_irdata",   iddr_icache_rdata, LINE_A5);
      chk_vec("t1_dresp",    dddr_dcache_resp, 1'b0);
      chk_vec("t1_cmd_drop", arb_ddr_read, 1'b0);
      icache_iddr_read = 1'b0;
      tick();
      chk_vec("t1_pulse",    iddr_icache_resp, 1'b0);
      chk_vec("t1_rd_hold",  iddr_icache_rdata, LINE_A5);
      chk_vec("t1_dresp2",   dddr_dcache_resp, 1'b0);

      // simultaneous requests right after reset: dcache wins the first tie
      do_reset();
      icache_iddr_addr  = 32'h0000_0100;
      icache_iddr_read  = 1'b1;
      dcache_dddr_addr  = 32'h0000_0200;
      dcache_dddr_write = 1'b1;
      dcache_dddr_wdata = WD_1234;
      tick();
      chk_vec("t2_d_wr",    arb_ddr_write, 1'b1);
      chk_vec("t2_d_rd",    arb_ddr_read, 1'b0);
      chk_vec("t2_d_addr",  arb_ddr_addr, 32'h0000_0200);
      chk_vec("t2_d_wdata", arb_ddr_wdata, WD_1234);
      ddr_reply(LINE_77);
      chk_vec("t2_dresp",   dddr_dcache_resp, 1'b1);
      chk_vec("t2_iresp0",  iddr_icache_resp, 1'b0);
      chk_vec("t2_wr_keep", dddr_dcache_rdata, '0);
      chk_idle_port("t2_gap1");
      dcache_dddr_write = 1'b0;
      tick();
      chk_idle_port("t2_gap2");
      chk_vec("t2_dpulse",  dddr_dcache_resp, 1'b0);
      tick();
      chk_vec("t2_i_rd",    arb_ddr_read, 1'b1);
      chk_vec("t2_i_addr",  arb_ddr_addr, 32'h0000_0100);
      ddr_reply(LINE_C3);
      chk_vec("t2_iresp",   iddr_icache_resp, 1'b1);
      chk_vec("t2_irdata",  iddr_icache_rdata, LINE_C3);
      chk_vec("t2_nox",     dddr_dcache_rdata, '0);
      icache_iddr_read = 1'b0;
      tick();

      // both hold requests: grants alternate D, I, D, I
      icache_iddr_addr = 32'h0000_0400;
      icache_iddr_read = 1'b1;
      dcache_dddr_addr = 32'h0000_0500;
      dcache_dddr_read = 1'b1;
      exp_d = '0;
      for (int k = 0; k < 4; k++) begin
         b      = 8'h10 + 8'(k);
         line_k = {32{b}};
         tick();
         chk_vec($sformatf("t3_rd_%0d", k), arb_ddr_read, 1'b1);
         chk_vec($sformatf("t3_addr_%0d", k), arb_ddr_addr,
                 (k % 2 == 0) ? 32'h0000_0500 : 32'h0000_0400);
         ddr_reply(line_k);
         if (k % 2 == 0) begin
            exp_d = line_k;
            chk_vec($sformatf("t3_dresp_%0d", k), dddr_dcache_resp, 1'b1);
            chk_vec($sformatf("t3_drd_%0d", k), dddr_dcache_rdata, line_k);
         end else begin
            chk_vec($sformatf("t3_iresp_%0d", k), iddr_icache_resp, 1'b1);
            chk_vec($sformatf("t3_ird_%0d", k), iddr_icache_rdata, line_k);
            chk_vec($sformatf("t3_dkeep_%0d", k), dddr_dcache_rdata, exp_d);
         end
         tick();
      end
      icache_iddr_read = 1'b0;
      dcache_dddr_read = 1'b0;
      tick();

      // dcache read+write together: write wins
      dcache_dddr_addr  = 32'h0000_0300;
      dcache_dddr_read  = 1'b1;
      dcache_dddr_write = 1'b1;
      dcache_dddr_wdata = WD_DEAD;
      tick();
      chk_vec("t4_wr",    arb_ddr_write, 1'b1);
      chk_vec("t4_rd",    arb_ddr_read, 1'b0);
      chk_vec("t4_addr",  arb_ddr_addr, 32'h0000_0300);
      chk_vec("t4_wdata", arb_ddr_wdata, WD_DEAD);
      ddr_reply(LINE_77);
      chk_vec("t4_dresp", dddr_dcache_resp, 1'b1);
      chk_vec("t4_keep",  dddr_dcache_rdata, exp_d);
      dcache_dddr_read  = 1'b0;
      dcache_dddr_write = 1'b0;
      tick();
      // a stray DDR resp while idle changes nothing
      ddr_reply(LINE_EE);
      chk_vec("t4_stray_i", iddr_icache_resp, 1'b0);
      chk_vec("t4_stray_d", dddr_dcache_resp, 1'b0);
      chk_vec("t4_stray_rd", dddr_dcache_rdata, exp_d);
      chk_idle_port("t4_stray");

      // icache drops its request mid-transaction; it still completes
      icache_iddr_addr = 32'h0000_0600;
      icache_iddr_read = 1'b1;
      tick();
      chk_vec("t5_rd",      arb_ddr_read, 1'b1);
      icache_iddr_read = 1'b0;
      icache_iddr_addr = 32'h0000_0FF0;
      tick();
      tick();
      chk_vec("t5_held_rd", arb_ddr_read, 1'b1);
      chk_vec("t5_held_a",  arb_ddr_addr, 32'h0000_0600);
      ddr_reply(LINE_5A);
      chk_vec("t5_iresp",   iddr_icache_resp, 1'b1);
      chk_vec("t5_irdata",  iddr_icache_rdata, LINE_5A);
      tick();

      // reset while a dcache write is in flight
      dcache_dddr_addr  = 32'h0000_0700;
      dcache_dddr_write = 1'b1;
      dcache_dddr_wdata = WD_0707;
      tick();
      chk_vec("t6_wr",      arb_ddr_write, 1'b1);
      dcache_dddr_write = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_vec("t6_wr0",     arb_ddr_write, 1'b0);
      chk_vec("t6_rd0",     arb_ddr_read, 1'b0);
      chk_vec("t6_addr0",   arb_ddr_addr, '0);
      chk_vec("t6_wdata0",  arb_ddr_wdata, '0);
      chk_vec("t6_irdata0", iddr_icache_rdata, '0);
      chk_vec("t6_drdata0", dddr_dcache_rdata, '0);
      chk_vec("t6_dresp0",  dddr_dcache_resp, 1'b0);
      tick();
      chk_vec("t6_noresp",  dddr_dcache_resp, 1'b0);
      icache_iddr_addr = 32'h0000_0800;
      icache_iddr_read = 1'b1;
      dcache_dddr_addr = 32'h0000_0900;
      dcache_dddr_read = 1'b1;
      tick();
      chk_vec("t6_tie_rd",  arb_ddr_read, 1'b1);
      chk_vec("t6_tie_a",   arb_ddr_addr, 32'h0000_0900);
      ddr_reply(LINE_C3);
      chk_vec("t6_dresp",   dddr_dcache_resp, 1'b1);
      chk_vec("t6_drdata",  dddr_dcache_rdata, LINE_C3);
      dcache_dddr_read = 1'b0;
      tick();
      tick();
      chk_vec("t6_i_addr",  arb_ddr_addr, 32'h0000_0800);
      chk_vec("t6_i_rd",    arb_ddr_read, 1'b1);
      ddr_reply(LINE_A5);
      chk_vec("t6_iresp",   iddr_icache_resp, 1'b1);
      chk_vec("t6_irdata",  iddr_icache_rdata, LINE_A5);
      icache_iddr_read = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
